// File: rtl/cache_pkg.sv
// Shared cache-path definitions: default line geometry, refill FSM states
// and the line-slot index helper.
package cache_pkg;

    localparam int WORD_WIDTH_DEF = 32;
    localparam int WORDS_DEF      = 4;

    typedef enum logic [1:0] {
        IDLE,
        FILL,
        DONE
    } state_t;

    // Slot of the cnt-th returned word when the refill starts at base; words is a power of two.
    function automatic int unsigned line_slot(input int unsigned base,
                                              input int unsigned cnt,
                                              input int unsigned words);
        return (base + cnt) & (words - 1);
    endfunction

endpackage

// File: rtl/refill_line_assembler.sv
// Packs the refill word stream from an FWFT FIFO into one cache line,
// critical word first, with an early critical-word pulse and a line handshake.
module refill_line_assembler
    import cache_pkg::*;
#(
    parameter int WORD_WIDTH = WORD_WIDTH_DEF,
    parameter int WORDS      = WORDS_DEF,
    parameter int OFF_W      = $clog2(WORDS)
) (
    input  logic                        CLK,
    input  logic                        RST,
    input  logic                        REQ_VALID,
    output logic                        REQ_READY,
    input  logic [OFF_W-1:0]            REQ_OFFSET,
    input  logic [WORD_WIDTH-1:0]       FIFO_DATA,
    input  logic                        FIFO_EMPTY,
    output logic                        FIFO_RD_ENB,
    output logic                        CRIT_VALID,
    output logic [WORD_WIDTH-1:0]       CRIT_DATA,
    output logic                        LINE_VALID,
    input  logic                        LINE_READY,
    output logic [WORD_WIDTH*WORDS-1:0] LINE_DATA
);

    state_t           state;
    logic [OFF_W-1:0] base;
    logic [OFF_W-1:0] cnt;
    logic [OFF_W-1:0] slot;
    logic             pop;

    // Popping only in FILL keeps words of a later refill queued in the FIFO.
    assign pop         = (state == FILL) && !FIFO_EMPTY;
    assign FIFO_RD_ENB = pop;
    assign REQ_READY   = (state == IDLE);
    assign LINE_VALID  = (state == DONE);
    assign slot        = OFF_W'(line_slot(32'(base), 32'(cnt), WORDS));

    always_ff @(posedge CLK) begin
        if (RST) begin
            state      <= IDLE;
            base       <= '0;
            cnt        <= '0;
            CRIT_VALID <= 1'b0;
            CRIT_DATA  <= '0;
            // NOTE: the line register is reset because its value is visible on LINE_DATA straight after reset.
            LINE_DATA  <= '0;
        end else begin
            // NOTE: default-low here, overridden below, is what makes CRIT_VALID a single-cycle pulse.
            CRIT_VALID <= 1'b0;
            unique case (state)
                IDLE: begin
                    if (REQ_VALID) begin
                        base  <= REQ_OFFSET;
                        cnt   <= '0;
                        state <= FILL;
                    end
                end
                FILL: begin
                    if (pop) begin
                        LINE_DATA[slot*WORD_WIDTH +: WORD_WIDTH] <= FIFO_DATA;
                        cnt <= cnt + 1'b1;
                        if (cnt == '0) begin
                            CRIT_DATA  <= FIFO_DATA;
                            CRIT_VALID <= 1'b1;
                        end
                        if (cnt == OFF_W'(WORDS - 1)) begin
                            state <= DONE;
                        end
                    end
                end
                DONE: begin
                    if (LINE_READY) begin
                        state <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_refill_line_assembler.sv
// Self-checking bench for refill_line_assembler: table-driven refills plus
// starvation, backpressure and reset sequences, checked through a scoreboard.
module tb_refill_line_assembler;
    import cache_pkg::*;

    localparam int WW = 32;
    localparam int NW = 4;
    localparam int OW = 2;
    localparam int LW = WW * NW;

    logic          clk = 1'b0;
    logic          rst;
    logic          req_valid;
    logic          req_ready;
    logic [OW-1:0] req_offset;
    logic [WW-1:0] fifo_data;
    logic          fifo_empty;
    logic          fifo_rd_enb;
    logic          crit_valid;
    logic [WW-1:0] crit_data;
    logic          line_valid;
    logic          line_ready;
    logic [LW-1:0] line_data;

    always #5 clk = ~clk;

    refill_line_assembler #(.WORD_WIDTH(WW), .WORDS(NW)) dut (
        .CLK        (clk),
        .RST        (rst),
        .REQ_VALID  (req_valid),
        .REQ_READY  (req_ready),
        .REQ_OFFSET (req_offset),
        .FIFO_DATA  (fifo_data),
        .FIFO_EMPTY (fifo_empty),
        .FIFO_RD_ENB(fifo_rd_enb),
        .CRIT_VALID (crit_valid),
        .CRIT_DATA  (crit_data),
        .LINE_VALID (line_valid),
        .LINE_READY (line_ready),
        .LINE_DATA  (line_data)
    );

    typedef struct {
        logic [OW-1:0] off;
        logic [LW-1:0] words;     // word k (stream order) at [k*WW +: WW]
        logic [LW-1:0] exp_line;  // slot i at [i*WW +: WW]
    } vec_t;

    vec_t          vecs[4];
    logic [WW-1:0] fifo_q[$];
    logic [WW-1:0] exp_crit_q[$];
    logic [LW-1:0] exp_line_q[$];

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int req_cyc = 0;
    int crit_seen_at = 0;
    int crit_cnt = 0;
    bit prev_crit = 1'b0;
    bit hs_seen = 1'b0;
    int lat;

    function automatic logic [LW-1:0] pk(input logic [WW-1:0] s0, input logic [WW-1:0] s1,
                                         input logic [WW-1:0] s2, input logic [WW-1:0] s3);
        return {s3, s2, s1, s0};
    endfunction

    task automatic check(input string name, input logic [LW-1:0] act, input logic [LW-1:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic refresh_fifo();
        fifo_empty = (fifo_q.size() == 0);
        fifo_data  = fifo_empty ? '0 : fifo_q[0];
    endtask

    task automatic push_words(input logic [LW-1:0] words);
        for (int k = 0; k < NW; k++) fifo_q.push_back(words[k*WW +: WW]);
        refresh_fifo();
    endtask

    // One clock: sample just before the edge, model the FIFO pop, monitor just after it.
    task automatic step();
        logic          pop_s;
        logic          hs_s;
        logic          rst_s;
        logic [LW-1:0] line_s;
        #3;
        pop_s  = fifo_rd_enb;
        hs_s   = line_valid && line_ready;
        rst_s  = rst;
        line_s = line_data;
        check("rd_enb_while_empty", LW'(pop_s && fifo_empty), '0);
        @(posedge clk);
        #1;
        cyc++;
        if (rst_s) fifo_q.delete();
        else if (pop_s && fifo_q.size() != 0) void'(fifo_q.pop_front());
        refresh_fifo();
        if (!rst_s && hs_s) begin
            hs_seen = 1'b1;
            check("crit_pulses_per_refill", LW'(crit_cnt), LW'(1));
            crit_cnt = 0;
            if (exp_line_q.size() == 0) check("unexpected_line", LW'(1), LW'(0));
            else check("line_data", line_s, exp_line_q.pop_front());
        end
        if (crit_valid) begin
            check("crit_consecutive", LW'(prev_crit), LW'(0));
            crit_cnt++;
            crit_seen_at = cyc;
            if (exp_crit_q.size() == 0) check("unexpected_crit", LW'(1), LW'(0));
            else check("crit_data", LW'(crit_data), LW'(exp_crit_q.pop_front()));
        end
        prev_crit = crit_valid;
        @(negedge clk);
    endtask

    task automatic request(input logic [OW-1:0] off, input logic [WW-1:0] crit,
                           input logic [LW-1:0] line, input bit expect_line);
        #1;
        check("req_ready_idle", LW'(req_ready), LW'(1));
        check("rd_enb_idle", LW'(fifo_rd_enb), LW'(0));
        exp_crit_q.push_back(crit);
        if (expect_line) exp_line_q.push_back(line);
        req_valid  = 1'b1;
        req_offset = off;
        step();
        req_valid = 1'b0;
        req_cyc   = cyc;
    endtask

    task automatic wait_line(output int latency);
        int n = 0;
        while (!line_valid && n < 40) begin
            step();
            n++;
        end
        check("line_timeout", LW'(!line_valid), LW'(0));
        latency = cyc - req_cyc + 1;
    endtask

    task automatic handshake();
        line_ready = 1'b1;
        hs_seen    = 1'b0;
        step();
        check("handshake_done", LW'(hs_seen), LW'(1));
        check("line_valid_one_cycle", LW'(line_valid), LW'(0));
    endtask

    initial begin
        vecs[0] = '{off: 2'd0, words: pk(32'hA0, 32'hA1, 32'hA2, 32'hA3),
                    exp_line: pk(32'hA0, 32'hA1, 32'hA2, 32'hA3)};
        vecs[1] = '{off: 2'd2, words: pk(32'hB0, 32'hB1, 32'hB2, 32'hB3),
                    exp_line: pk(32'hB2, 32'hB3, 32'hB0, 32'hB1)};
        vecs[2] = '{off: 2'd1, words: pk(32'hC0, 32'hC1, 32'hC2, 32'hC3),
                    exp_line: pk(32'hC3, 32'hC0, 32'hC1, 32'hC2)};
        vecs[3] = '{off: 2'd3, words: pk(32'hD0, 32'hD1, 32'hD2, 32'hD3),
                    exp_line: pk(32'hD1, 32'hD2, 32'hD3, 32'hD0)};

        rst        = 1'b1;
        req_valid  = 1'b0;
        req_offset = '0;
        line_ready = 1'b1;
        refresh_fifo();
        @(negedge clk);
        step();
        step();
        rst = 1'b0;
        check("rst_req_ready", LW'(req_ready), LW'(1));
        check("rst_rd_enb", LW'(fifo_rd_enb), LW'(0));
        check("rst_crit_valid", LW'(crit_valid), LW'(0));
        check("rst_crit_data", LW'(crit_data), LW'(0));
        check("rst_line_valid", LW'(line_valid), LW'(0));
        check("rst_line_data", line_data, '0);

        // Back-to-back refills from a preloaded FIFO.
        for (int i = 0; i < 4; i++) begin
            push_words(vecs[i].words);
            request(vecs[i].off, vecs[i].words[WW-1:0], vecs[i].exp_line, 1'b1);
            wait_line(lat);
            check("line_latency", LW'(lat), LW'(NW + 1));
            check("crit_after_first_pop", LW'(crit_seen_at - req_cyc), LW'(1));
            handshake();
        end

        // Starved FIFO: three empty cycles between words.
        request(2'd1, 32'h50, pk(32'h53, 32'h50, 32'h51, 32'h52), 1'b1);
        for (int k = 0; k < NW; k++) begin
            fifo_q.push_back(32'h50 + WW'(k));
            refresh_fifo();
            step();
            if (k == NW - 1) begin
                check("starve_line_valid", LW'(line_valid), LW'(1));
            end else begin
                check("starve_line_early", LW'(line_valid), LW'(0));
                repeat (3) step();
                check("starve_no_pop", LW'(fifo_rd_enb), LW'(0));
            end
        end
        handshake();

        // Backpressure with a second request and its words already waiting.
        line_ready = 1'b0;
        push_words(pk(32'hE0, 32'hE1, 32'hE2, 32'hE3));
        push_words(pk(32'hF0, 32'hF1, 32'hF2, 32'hF3));
        request(2'd0, 32'hE0, pk(32'hE0, 32'hE1, 32'hE2, 32'hE3), 1'b1);
        wait_line(lat);
        req_valid  = 1'b1;
        req_offset = 2'd3;
        for (int k = 0; k < 10; k++) begin
            step();
            check("bp_rd_enb", LW'(fifo_rd_enb), LW'(0));
            check("bp_req_ready", LW'(req_ready), LW'(0));
            check("bp_line_valid", LW'(line_valid), LW'(1));
            check("bp_line_stable", line_data, pk(32'hE0, 32'hE1, 32'hE2, 32'hE3));
        end
        check("bp_fifo_kept", LW'(fifo_q.size()), LW'(NW));
        exp_crit_q.push_back(32'hF0);
        exp_line_q.push_back(pk(32'hF1, 32'hF2, 32'hF3, 32'hF0));
        handshake();
        check("bp_idle_after_hs", LW'(req_ready), LW'(1));
        step();
        req_valid = 1'b0;
        req_cyc   = cyc;
        wait_line(lat);
        check("bp_second_latency", LW'(lat), LW'(NW + 1));
        handshake();

        // Reset after two pops; the partial line is discarded.
        push_words(pk(32'h60, 32'h61, 32'h62, 32'h63));
        request(2'd2, 32'h60, '0, 1'b0);
        step();
        step();
        rst = 1'b1;
        step();
        rst       = 1'b0;
        crit_cnt  = 0;
        prev_crit = 1'b0;
        check("mid_rst_req_ready", LW'(req_ready), LW'(1));
        check("mid_rst_crit_valid", LW'(crit_valid), LW'(0));
        check("mid_rst_crit_data", LW'(crit_data), LW'(0));
        check("mid_rst_line_valid", LW'(line_valid), LW'(0));
        check("mid_rst_line_data", line_data, '0);
        check("mid_rst_crit_seen", LW'(exp_crit_q.size()), LW'(0));
        push_words(pk(32'h70, 32'h71, 32'h72, 32'h73));
        request(2'd1, 32'h70, pk(32'h73, 32'h70, 32'h71, 32'h72), 1'b1);
        wait_line(lat);
        handshake();

        check("scoreboard_empty", LW'(exp_crit_q.size() + exp_line_q.size()), LW'(0));
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

endmodule
